// File: rtl/uart_cmd_pkg.sv
// Shared constants, opcodes and state encodings for the UART command receiver.
// Imported by uart_rx_core and uart_cmd_rx.
package uart_cmd_pkg;

  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_STOP   = 8'h02;
  localparam logic [7:0] CMD_RESEND = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_SYNC,
    P_OP,
    P_ARG,
    P_CSUM
  } p_state_t;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver: 2-FF synchronizer, start/data/stop FSM.
// Ports: clk, rst (sync, active-high), rx in; byte_valid, byte_data, frame_err out.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

  logic          rx_m;
  logic          rx_s;
  rx_state_t     state;
  rx_state_t     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    shreg;
  logic [7:0]    sh_n;
  logic          brk;
  logic          brk_n;
  logic          bv_n;
  logic [7:0]    data_n;
  logic          fe_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      brk        <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= sh_n;
      brk        <= brk_n;
      byte_valid <= bv_n;
      byte_data  <= data_n;
      frame_err  <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    brk_n   = brk;
    bv_n    = 1'b0;
    data_n  = byte_data;
    fe_n    = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_n = RX_START;
          cnt_n   = CW'(HALF - 1);
        end
      end
      RX_START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rx_s) begin
          // line rose before mid-start: glitch
          state_n = RX_IDLE;
        end else begin
          state_n = RX_DATA;
          cnt_n   = CW'(CLKS_PER_BIT - 1);
          bit_n   = '0;
        end
      end
      RX_DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          sh_n  = {rx_s, shreg[7:1]};
          cnt_n = CW'(CLKS_PER_BIT - 1);
          bit_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (brk) begin
          // break: hold until the line idles again
          if (rx_s) begin
            brk_n   = 1'b0;
            state_n = RX_IDLE;
          end
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (rx_s) begin
          bv_n    = 1'b1;
          data_n  = shreg;
          state_n = RX_IDLE;
        end else begin
          fe_n  = 1'b1;
          brk_n = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: bytes from uart_rx_core parsed into SYNC/OP/ARG[4]/CSUM frames.
// Ports: iClk_100MHz, iRst, iRx in; byte, command and error pulses out.
// Optional inter-byte timeout compiled in with UART_CMD_TIMEOUT_EN.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned BAUD_RATE      = 115_200,
  parameter logic [7:0]  SYNC_BYTE      = UART_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        iClk_100MHz,
  input  logic        iRst,
  input  logic        iRx,
  output logic        oByteValid,
  output logic [7:0]  oByteData,
  output logic        oCmdValid,
  output logic [7:0]  oCmdOpcode,
  output logic [31:0] oCmdArg,
  output logic        oFrameErr,
  output logic        oChecksumErr,
  output logic        oTimeoutErr
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);

  uart_rx_core #(
    .CLKS_PER_BIT(CPB)
  ) u_core (
    .clk       (iClk_100MHz),
    .rst       (iRst),
    .rx        (iRx),
    .byte_valid(oByteValid),
    .byte_data (oByteData),
    .frame_err (oFrameErr)
  );

  p_state_t    p_state;
  p_state_t    p_n;
  logic [1:0]  idx;
  logic [1:0]  idx_n;
  logic [7:0]  csum;
  logic [7:0]  csum_n;
  logic [7:0]  op;
  logic [7:0]  op_n;
  logic [31:0] arg;
  logic [31:0] arg_n;
  logic        cv_n;
  logic [7:0]  cop_n;
  logic [31:0] carg_n;
  logic        ce_n;
  logic        to_n;
  logic        timed_out;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);

  logic [GW-1:0] gap;

  assign timed_out = (gap == GW'(TIMEOUT_CYCLES));

  always_ff @(posedge iClk_100MHz) begin
    if (iRst || oByteValid || p_state == P_SYNC) begin
      gap <= '0;
    end else if (!timed_out) begin
      gap <= gap + 1'b1;
    end
  end

  always_ff @(posedge iClk_100MHz) begin
    if (iRst) begin
      oTimeoutErr <= 1'b0;
    end else begin
      oTimeoutErr <= to_n;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign oTimeoutErr = 1'b0;
`endif

  always_ff @(posedge iClk_100MHz) begin
    if (iRst) begin
      p_state      <= P_SYNC;
      idx          <= '0;
      csum         <= '0;
      op           <= '0;
      arg          <= '0;
      oCmdValid    <= 1'b0;
      oCmdOpcode   <= '0;
      oCmdArg      <= '0;
      oChecksumErr <= 1'b0;
    end else begin
      p_state      <= p_n;
      idx          <= idx_n;
      csum         <= csum_n;
      op           <= op_n;
      arg          <= arg_n;
      oCmdValid    <= cv_n;
      oCmdOpcode   <= cop_n;
      oCmdArg      <= carg_n;
      oChecksumErr <= ce_n;
    end
  end

  always_comb begin
    p_n    = p_state;
    idx_n  = idx;
    csum_n = csum;
    op_n   = op;
    arg_n  = arg;
    cv_n   = 1'b0;
    cop_n  = oCmdOpcode;
    carg_n = oCmdArg;
    ce_n   = 1'b0;
    to_n   = 1'b0;
    if (oFrameErr) begin
      p_n = P_SYNC;
    end else if (oByteValid) begin
      unique case (p_state)
        P_SYNC: begin
          if (oByteData == SYNC_BYTE) begin
            p_n = P_OP;
          end
        end
        P_OP: begin
          op_n   = oByteData;
          csum_n = oByteData;
          idx_n  = '0;
          p_n    = P_ARG;
        end
        P_ARG: begin
          arg_n[{idx, 3'b000} +: 8] = oByteData;
          csum_n = csum ^ oByteData;
          idx_n  = idx + 1'b1;
          if (idx == 2'd3) begin
            p_n = P_CSUM;
          end
        end
        P_CSUM: begin
          if (oByteData == csum) begin
            cv_n   = 1'b1;
            cop_n  = op;
            carg_n = arg;
          end else begin
            ce_n = 1'b1;
          end
          p_n = P_SYNC;
        end
        default: p_n = P_SYNC;
      endcase
    end else if (timed_out && p_state != P_SYNC) begin
      // a byte arriving this cycle takes priority over the timeout
      p_n  = P_SYNC;
      to_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx with a frame-level reference model.
// Runs at 32 clocks per bit to keep the run short.
module tb_uart_cmd_rx;

  localparam int unsigned CPB = 32;
  localparam int unsigned TO_CYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        bv;
  logic [7:0]  bdata;
  logic        cv;
  logic [7:0]  cop;
  logic [31:0] carg;
  logic        fe;
  logic        ce;
  logic        to;

  uart_cmd_rx #(
    .CLK_FREQ      (100_000_000),
    .BAUD_RATE     (3_125_000),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .iClk_100MHz (clk),
    .iRst        (rst),
    .iRx         (rx),
    .oByteValid  (bv),
    .oByteData   (bdata),
    .oCmdValid   (cv),
    .oCmdOpcode  (cop),
    .oCmdArg     (carg),
    .oFrameErr   (fe),
    .oChecksumErr(ce),
    .oTimeoutErr (to)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_bv = 0;
  int n_cv = 0;
  int n_ce = 0;
  int n_fe = 0;
  int n_to = 0;
  int fe_pend = 0;
  bit chk_en = 0;
  bit to_ok = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  frm[$];
  logic        exp_cv = 0;
  logic        exp_ce = 0;
  logic [7:0]  m_op = '0;
  logic [31:0] m_arg = '0;
  logic [7:0]  m_byte = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  // frame-level model: collect 7 bytes after a sync, validate by xor
  function automatic void model_byte(logic [7:0] b);
    logic [7:0] x;
    if (frm.size() != 0 || b == 8'hA5) frm.push_back(b);
    if (frm.size() == 7) begin
      x = frm[1] ^ frm[2] ^ frm[3] ^ frm[4] ^ frm[5];
      if (x == frm[6]) begin
        exp_cv = 1'b1;
        m_op   = frm[1];
        m_arg  = {frm[5], frm[4], frm[3], frm[2]};
      end else begin
        exp_ce = 1'b1;
      end
      frm.delete();
    end
  endfunction

  initial begin : compare
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmd_valid", 32'(cv), 32'(exp_cv));
        chk("csum_err", 32'(ce), 32'(exp_ce));
        chk("opcode", 32'(cop), 32'(m_op));
        chk("arg", carg, m_arg);
        chk("timeout_unexp", 32'(to & ~to_ok), 32'd0);
        exp_cv = 1'b0;
        exp_ce = 1'b0;
        if (cv) n_cv++;
        if (ce) n_ce++;
        if (bv) begin
          n_bv++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL byte_unexp: got %h want none", bdata);
          end else begin
            e = exp_q.pop_front();
            m_byte = e;
            model_byte(e);
          end
        end
        chk("byte_data", 32'(bdata), 32'(m_byte));
        if (fe) begin
          n_fe++;
          frm.delete();
          if (fe_pend == 0) begin
            total++;
            bad++;
            $display("FAIL frame_err_unexp: got 1 want 0");
          end else begin
            fe_pend--;
          end
        end
        if (to) begin
          n_to++;
          frm.delete();
        end
      end
    end
  end

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) exp_q.push_back(b);
    else fe_pend++;
    @(negedge clk);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [55:0] f);
    for (int i = 0; i < 7; i++) send_byte(f[55-8*i -: 8], 1'b1);
  endtask

  task automatic seg(input string nm, input int xbv, input int xcv,
                     input int xce, input int xfe, input int xto);
    repeat (CPB) @(negedge clk);
    @(posedge clk);
    chk({nm, "_bv"}, n_bv, xbv);
    chk({nm, "_cv"}, n_cv, xcv);
    chk({nm, "_ce"}, n_ce, xce);
    chk({nm, "_fe"}, n_fe, xfe);
    chk({nm, "_to"}, n_to, xto);
    chk({nm, "_q"}, exp_q.size(), 0);
    n_bv = 0;
    n_cv = 0;
    n_ce = 0;
    n_fe = 0;
    n_to = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    frm.delete();
    fe_pend = 0;
    exp_cv = 0;
    exp_ce = 0;
    m_op = '0;
    m_arg = '0;
    m_byte = '0;
    chk("rst_bv", 32'(bv), 0);
    chk("rst_bdata", 32'(bdata), 0);
    chk("rst_cv", 32'(cv), 0);
    chk("rst_op", 32'(cop), 0);
    chk("rst_arg", carg, 0);
    chk("rst_fe", 32'(fe), 0);
    chk("rst_ce", 32'(ce), 0);
    chk("rst_to", 32'(to), 0);
    chk_en = 1;
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);

    send_frame(56'hA5_01_E8_03_00_00_EA);
    seg("t1", 7, 1, 0, 0, 0);
    chk("t1_op_lit", 32'(cop), 32'h01);
    chk("t1_arg_lit", carg, 32'h0000_03E8);

    send_frame(56'hA5_01_E8_03_00_00_EB);
    seg("t2a", 7, 0, 1, 0, 0);
    chk("t2_arg_kept", carg, 32'h0000_03E8);
    send_frame(56'hA5_02_00_00_00_00_02);
    seg("t2b", 7, 1, 0, 0, 0);
    chk("t2_op_lit", 32'(cop), 32'h02);
    chk("t2_arg_lit", carg, 32'h0);

    send_byte(8'h55, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    seg("t3a", 0, 0, 0, 1, 0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(56'hA5_04_00_00_00_00_04);
    seg("t3b", 7, 1, 0, 0, 0);
    chk("t3_op_lit", 32'(cop), 32'h04);

    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    seg("t4a", 0, 0, 0, 0, 0);
    send_frame(56'hA5_01_E8_03_00_00_EA);
    seg("t4b", 7, 1, 0, 0, 0);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hE8, 1'b1);
    repeat (CPB) @(negedge clk);
    do_reset();
    send_frame(56'hA5_01_E8_03_00_00_EA);
    seg("t5", 10, 1, 0, 0, 0);
    chk("t5_op_lit", 32'(cop), 32'h01);

`ifdef UART_CMD_TIMEOUT_EN
    to_ok = 1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (TO_CYC + 10) @(negedge clk);
    to_ok = 0;
    send_frame(56'hA5_03_00_00_00_00_03);
    seg("t6", 9, 1, 0, 0, 1);
    chk("t6_op_lit", 32'(cop), 32'h03);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
